// File: rtl/spi_status_pkg.sv
// Shared types and constants for the SPI status responder.
// Holds the frame FSM states, the register map addresses and the frame length.
package spi_status_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] ADDR_SCORE_LO = 3'd0;
  localparam logic [2:0] ADDR_SCORE_HI = 3'd1;
  localparam logic [2:0] ADDR_LIVES    = 3'd2;
  localparam logic [2:0] ADDR_FRUITS   = 3'd3;
  localparam logic [2:0] ADDR_STATUS   = 3'd4;
  localparam logic [2:0] ADDR_KEYCODE  = 3'd5;
  localparam logic [2:0] ADDR_RSVD     = 3'd6;
  localparam logic [2:0] ADDR_ID       = 3'd7;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI pin with rise/fall detection
// against a registered copy of the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // Reset to the pin's idle level so no spurious edge appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_status_slave.sv
// SPI mode-0 responder: an external master reads a snapshot of the game state
// and can write a keycode. 16-bit frames, MSB first: command byte then data byte.
//
// state | meaning
// IDLE  | no frame; MISO tri-stated, waiting for ss_n to fall
// CMD   | shifting in the command byte on sclk rising edges
// DATA  | shifting read data out on falling edges, write data in on rising edges
// DONE  | all 16 bits seen; extra sclk edges ignored until ss_n rises
module spi_status_slave
  import spi_status_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter int         SCORE_W     = 10
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               spi_sclk,
  input  logic               spi_ss_n,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic               spi_miso_oe,
  input  logic [SCORE_W-1:0] score,
  input  logic [7:0]         lives,
  input  logic [3:0]         fruits,
  input  logic               win,
  input  logic               lose,
  output logic [7:0]         keycode,
  output logic               keycode_wr,
  output logic               frame_err,
  output logic               busy
);

  localparam logic [4:0] CMD_LAST   = 5'(CMD_BITS - 1);
  localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS - 1);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk   (Clk),
    .rst_n (Reset_n),
    .d     (spi_sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk   (Clk),
    .rst_n (Reset_n),
    .d     (spi_ss_n),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  // MOSI uses the same depth as sclk so the sampled bit lines up with the edge detect.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

  state_t             state_q, state_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [6:0]         rx_q, rx_d;
  logic [7:0]         tx_q, tx_d;
  logic               w_q, w_d;
  logic [2:0]         addr_q, addr_d;
  logic               miso_q, miso_d;
  logic               oe_q, oe_d;
  logic [7:0]         keycode_q, keycode_d;
  logic               kwr_q, kwr_d;
  logic               ferr_q, ferr_d;
  logic [SCORE_W-1:0] score_sh_q, score_sh_d;
  logic [7:0]         lives_sh_q, lives_sh_d;
  logic [3:0]         fruits_sh_q, fruits_sh_d;
  logic               win_sh_q, win_sh_d;
  logic               lose_sh_q, lose_sh_d;

  logic [7:0]  cmd_byte;
  logic [7:0]  rd_data;
  logic [15:0] score_ext;

  assign cmd_byte = {rx_q, mosi_s};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      w_q         <= 1'b0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      keycode_q   <= '0;
      kwr_q       <= 1'b0;
      ferr_q      <= 1'b0;
      score_sh_q  <= '0;
      lives_sh_q  <= '0;
      fruits_sh_q <= '0;
      win_sh_q    <= 1'b0;
      lose_sh_q   <= 1'b0;
      mosi_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      w_q         <= w_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      keycode_q   <= keycode_d;
      kwr_q       <= kwr_d;
      ferr_q      <= ferr_d;
      score_sh_q  <= score_sh_d;
      lives_sh_q  <= lives_sh_d;
      fruits_sh_q <= fruits_sh_d;
      win_sh_q    <= win_sh_d;
      lose_sh_q   <= lose_sh_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  // ss_n rising has priority over any sclk edge seen on the same Clk.
  always_comb begin
    state_d = state_q;
    if (ss_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ss_fall) state_d = CMD;
        CMD:     if (sclk_rise && bit_cnt_q == CMD_LAST) state_d = DATA;
        DATA:    if (sclk_rise && bit_cnt_q == FRAME_LAST) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    score_ext = '0;
    score_ext[SCORE_W-1:0] = score_sh_q;
    case (cmd_byte[2:0])
      ADDR_SCORE_LO: rd_data = score_ext[7:0];
      ADDR_SCORE_HI: rd_data = score_ext[15:8];
      ADDR_LIVES:    rd_data = lives_sh_q;
      ADDR_FRUITS:   rd_data = {4'b0, fruits_sh_q};
      ADDR_STATUS:   rd_data = {6'b0, lose_sh_q, win_sh_q};
      ADDR_KEYCODE:  rd_data = keycode_q;
      ADDR_RSVD:     rd_data = 8'h00;
      ADDR_ID:       rd_data = ID_VALUE;
      default:       rd_data = 8'h00;
    endcase
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    w_d         = w_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    keycode_d   = keycode_q;
    kwr_d       = 1'b0;
    ferr_d      = 1'b0;
    score_sh_d  = score_sh_q;
    lives_sh_d  = lives_sh_q;
    fruits_sh_d = fruits_sh_q;
    win_sh_d    = win_sh_q;
    lose_sh_d   = lose_sh_q;
    if (ss_rise) begin
      oe_d   = 1'b0;
      miso_d = 1'b0;
      if (state_q == CMD || state_q == DATA) ferr_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // Snapshot so each frame reads a coherent view of the game state.
          if (ss_fall) begin
            score_sh_d  = score;
            lives_sh_d  = lives;
            fruits_sh_d = fruits;
            win_sh_d    = win;
            lose_sh_d   = lose;
            bit_cnt_d   = '0;
            oe_d        = 1'b1;
            miso_d      = 1'b0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            rx_d      = cmd_byte[6:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == CMD_LAST) begin
              w_d    = cmd_byte[7];
              addr_d = cmd_byte[2:0];
              tx_d   = cmd_byte[7] ? 8'h00 : rd_data;
            end
          end
        end
        DATA: begin
          if (sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (sclk_rise) begin
            rx_d      = cmd_byte[6:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == FRAME_LAST && w_q && addr_q == ADDR_KEYCODE) begin
              keycode_d = cmd_byte;
              kwr_d     = 1'b1;
            end
          end
        end
        DONE: begin
          miso_d = 1'b0;
        end
        default: begin
          miso_d = 1'b0;
        end
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign keycode     = keycode_q;
  assign keycode_wr  = kwr_q;
  assign frame_err   = ferr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_status_slave.sv
// Directed bench for spi_status_slave: table of full frames plus hand-written
// snapshot, abort and asynchronous-reset sequences. Master runs at Clk/8.
module tb_spi_status_slave;

  logic       Clk;
  logic       Reset_n;
  logic       spi_sclk, spi_ss_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [9:0] score;
  logic [7:0] lives;
  logic [3:0] fruits;
  logic       win, lose;
  logic [7:0] keycode;
  logic       keycode_wr, frame_err, busy;

  int checks   = 0;
  int failures = 0;
  int kwr_cycles  = 0;
  int ferr_cycles = 0;
  int oe_viol     = 0;
  int ss_high_cnt = 0;

  spi_status_slave #(.SYNC_STAGES(2), .ID_VALUE(8'hA5), .SCORE_W(10)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .spi_sclk    (spi_sclk),
    .spi_ss_n    (spi_ss_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .score       (score),
    .lives       (lives),
    .fruits      (fruits),
    .win         (win),
    .lose        (lose),
    .keycode     (keycode),
    .keycode_wr  (keycode_wr),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  always @(posedge Clk) begin
    if (keycode_wr) kwr_cycles++;
    if (frame_err) ferr_cycles++;
    if (spi_ss_n) ss_high_cnt++;
    else ss_high_cnt = 0;
    if (Reset_n && spi_ss_n && spi_miso_oe && ss_high_cnt > 4) oe_viol++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clock_bits(input logic [15:0] fr, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = fr[15-i];
      repeat (4) @(negedge Clk);
      if (i >= 8) rd = {rd[6:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (4) @(negedge Clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [7:0] wd, input int nbits,
                      input bit chg, input logic [9:0] new_score,
                      output logic [7:0] rd, output logic busy_mid);
    spi_ss_n = 1'b0;
    repeat (4) @(negedge Clk);
    busy_mid = busy;
    if (chg) score = new_score;
    clock_bits({cmd, wd}, nbits, rd);
    repeat (4) @(negedge Clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge Clk);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic [7:0] exp_key;
    int         exp_kwr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [7:0] rd;
    logic       bm;
    int         k0, f0;

    vecs[0]  = '{8'h07, 8'h00, 8'hA5, 8'h00, 0};
    vecs[1]  = '{8'h00, 8'h00, 8'hC7, 8'h00, 0};
    vecs[2]  = '{8'h01, 8'h00, 8'h02, 8'h00, 0};
    vecs[3]  = '{8'h85, 8'h1A, 8'h00, 8'h1A, 1};
    vecs[4]  = '{8'h05, 8'h00, 8'h1A, 8'h1A, 0};
    vecs[5]  = '{8'h82, 8'hFF, 8'h00, 8'h1A, 0};
    vecs[6]  = '{8'h04, 8'h00, 8'h01, 8'h1A, 0};
    vecs[7]  = '{8'h02, 8'h00, 8'h03, 8'h1A, 0};
    vecs[8]  = '{8'h03, 8'h00, 8'h09, 8'h1A, 0};
    vecs[9]  = '{8'h06, 8'h00, 8'h00, 8'h1A, 0};
    vecs[10] = '{8'hF5, 8'h5C, 8'h00, 8'h5C, 1};
    vecs[11] = '{8'h7D, 8'h00, 8'h5C, 8'h5C, 0};

    Reset_n  = 1'b0;
    spi_sclk = 1'b0;
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    score    = 10'h2C7;
    lives    = 8'h03;
    fruits   = 4'h9;
    win      = 1'b1;
    lose     = 1'b0;

    repeat (5) @(negedge Clk);
    chk("rst_keycode", 32'(keycode), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_oe", 32'(spi_miso_oe), 32'h0);
    chk("rst_miso", 32'(spi_miso), 32'h0);
    chk("rst_kwr", 32'(keycode_wr), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    Reset_n = 1'b1;
    repeat (10) @(negedge Clk);

    for (int i = 0; i < 12; i++) begin
      k0 = kwr_cycles;
      f0 = ferr_cycles;
      xfer(vecs[i].cmd, vecs[i].wd, 16, 1'b0, 10'h000, rd, bm);
      chk($sformatf("v%0d_rd", i), 32'(rd), 32'(vecs[i].exp_rd));
      chk($sformatf("v%0d_key", i), 32'(keycode), 32'(vecs[i].exp_key));
      chk($sformatf("v%0d_kwr", i), 32'(kwr_cycles - k0), 32'(vecs[i].exp_kwr));
      chk($sformatf("v%0d_ferr", i), 32'(ferr_cycles - f0), 32'h0);
      chk($sformatf("v%0d_busy_mid", i), 32'(bm), 32'h1);
      chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'h0);
      chk($sformatf("v%0d_oe_end", i), 32'(spi_miso_oe), 32'h0);
    end

    // Score changes after ss_n falls: the frame still returns the snapshot.
    xfer(8'h00, 8'h00, 16, 1'b1, 10'h001, rd, bm);
    chk("snap_lo", 32'(rd), 32'hC7);
    xfer(8'h00, 8'h00, 16, 1'b0, 10'h000, rd, bm);
    chk("snap_next_lo", 32'(rd), 32'h01);
    score = 10'h2C7;

    // Abort after 12 sclk cycles of a keycode write.
    k0 = kwr_cycles;
    f0 = ferr_cycles;
    xfer(8'h85, 8'h33, 12, 1'b0, 10'h000, rd, bm);
    chk("abort_key", 32'(keycode), 32'h5C);
    chk("abort_kwr", 32'(kwr_cycles - k0), 32'h0);
    chk("abort_ferr", 32'(ferr_cycles - f0), 32'h1);
    chk("abort_busy", 32'(busy), 32'h0);
    k0 = kwr_cycles;
    f0 = ferr_cycles;
    xfer(8'h85, 8'h77, 16, 1'b0, 10'h000, rd, bm);
    chk("post_abort_key", 32'(keycode), 32'h77);
    chk("post_abort_kwr", 32'(kwr_cycles - k0), 32'h1);
    chk("post_abort_ferr", 32'(ferr_cycles - f0), 32'h0);
    xfer(8'h05, 8'h00, 16, 1'b0, 10'h000, rd, bm);
    chk("post_abort_rd", 32'(rd), 32'h77);

    // Asynchronous reset during the data byte of an ID read.
    spi_ss_n = 1'b0;
    repeat (4) @(negedge Clk);
    clock_bits(16'h0700, 10, rd);
    chk("mid_busy", 32'(busy), 32'h1);
    chk("mid_oe", 32'(spi_miso_oe), 32'h1);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("arst_keycode", 32'(keycode), 32'h00);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_oe", 32'(spi_miso_oe), 32'h0);
    chk("arst_miso", 32'(spi_miso), 32'h0);
    chk("arst_kwr", 32'(keycode_wr), 32'h0);
    chk("arst_ferr", 32'(frame_err), 32'h0);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (8) @(negedge Clk);
    f0 = ferr_cycles;
    xfer(8'h07, 8'h00, 16, 1'b0, 10'h000, rd, bm);
    chk("arst_id_rd", 32'(rd), 32'hA5);
    chk("arst_id_ferr", 32'(ferr_cycles - f0), 32'h0);
    chk("arst_key_hold", 32'(keycode), 32'h00);

    chk("oe_while_ss_high", 32'(oe_viol), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_status_slave.md
Name: spi_status_slave

Overview:
- SPI mode-0 slave (responder) on spare Arduino header pins; lets an external SPI master read game state and inject a keycode.
- It is the opposite end of the SPI link the SoC drives as master toward the USB host chip.
- Sits beside score_reg, lives_reg and fruits_reg at top level, reads their outputs, and produces a keycode write path usable in place of the USB keycode.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on spi_sclk, spi_ss_n and spi_mosi (minimum 2).
- ID_VALUE, 8'hA5: constant returned at address 7.
- SCORE_W, 10: score input width (at most 16).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous, active-low reset.
- spi_sclk  in  1  SPI clock from master; maximum frequency Clk/8.
- spi_ss_n  in  1  slave select, active low.
- spi_mosi  in  1  master-to-slave data.
- spi_miso  out  1  slave-to-master data.
- spi_miso_oe  out  1  MISO output enable; top level tri-states the pin when this is 0.
- score  in  SCORE_W  current score.
- lives  in  8  lives remaining.
- fruits  in  4  fruits remaining.
- win  in  1  game won flag.
- lose  in  1  game lost flag.
- keycode  out  8  last keycode written by the master.
- keycode_wr  out  1  one-Clk pulse when keycode is updated.
- frame_err  out  1  one-Clk pulse when a frame is aborted.
- busy  out  1  high while a frame is in progress (state is not IDLE).

Behaviour:
- Input synchronization and edge detection:
  - All SPI inputs pass through SYNC_STAGES flops before use.
  - Rising and falling edges of the synchronized sclk and ss_n are detected against a registered copy.
  - Edge-to-action latency is SYNC_STAGES+1 Clk.
- Reset values: keycode=0x00, keycode_wr=0, frame_err=0, busy=0, spi_miso=0, spi_miso_oe=0, state=IDLE, bit counter=0.
- Frame format (16 bits, MSB first):
  - Byte 0 is the command: bit7 = W (1 = write); bits[6:3] ignored; bits[2:0] = ADDR.
  - Byte 1 is data: read data on MISO, or write data on MOSI.
- Register map:
  - 0: score[7:0].
  - 1: {zero-pad, score[SCORE_W-1:8]}.
  - 2: lives.
  - 3: {4'b0, fruits}.
  - 4: {6'b0, lose, win}.
  - 5: keycode (read/write).
  - 6: 0x00.
  - 7: ID_VALUE.
- Write rules:
  - Writes to any address other than 5 are ignored.
  - No error is flagged for an ignored write.
- State machine:
  - IDLE -> CMD on ss_n falling edge. In this transition: snapshot score, lives, fruits, win and lose into shadow regs (a coherent 10-bit score read across addr 0/1 requires two frames; each frame is coherent within itself); clear bit counter; drive miso_oe=1, miso=0.
  - CMD: sample mosi on each sclk rising edge into rx shift register. On the 8th rising edge, latch W and ADDR, load tx shift register with the selected shadow value (0x00 for a write), then -> DATA.
  - DATA: on each sclk falling edge, miso=tx[7] and tx shifts left. The first falling edge after the command byte (falling edge 8) presents data bit 7. mosi is sampled on rising edges 9..16.
  - On rising edge 16 -> DONE. If W=1 and ADDR=5: keycode<=rx byte and keycode_wr pulses on the same Clk.
  - DONE: further sclk edges are ignored and miso=0.
  - Any state on ss_n rising edge -> IDLE with miso_oe=0.
- Abort: ss_n rises while in CMD or DATA.
  - The frame is discarded: no keycode update, no keycode_wr.
  - frame_err pulses 1 Clk.
  - State returns to IDLE.
- Simultaneous events: if an ss_n rising edge and an sclk edge are detected on the same Clk, ss_n wins and the frame is aborted if it is incomplete.
- Back-to-back frames: a new ss_n falling edge is accepted on the Clk after returning to IDLE. The master must hold ss_n high for at least SYNC_STAGES+2 Clk.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). The in-progress frame is lost, and the next ss_n falling edge starts a clean frame.
- Keycode hold: keycode holds its value until the next valid write or reset.

Decomposition:
- Package spi_status_pkg:
  - state enum {IDLE, CMD, DATA, DONE};
  - address constants ADDR_SCORE_LO..ADDR_ID (0..7);
  - FRAME_BITS=16.
- One sub-module, spi_sync_edge: parameterized synchronizer plus rise/fall detector. Instantiate it for sclk and ss_n; use the plain synchronizer path for mosi.

Test Plan:
- Read ID: master at Clk/8 sends 0x07,0x00 -> MISO byte 1 = 0xA5; keycode_wr never pulses; busy falls after ss_n rises.
- Read score: score=10'h2C7 held and two frames read addr 0 then 1 -> MISO returns 0xC7 then 0x02. Separately, score is changed to 0x001 after ss_n falls in a read of addr 0 -> MISO still returns 0xC7 (snapshot).
- Write keycode: frame 0x85,0x1A -> keycode=0x1A with a single-Clk keycode_wr aligned to the 16th sclk rising edge detect. A following read of addr 5 returns 0x1A.
- Abort: ss_n deasserted after 12 sclk cycles of a 0x85,0x33 frame -> keycode unchanged, keycode_wr=0, one frame_err pulse, busy=0; the next full frame works normally.
- Ignored write / status: write 0x82,0xFF -> lives input unaffected, no keycode_wr. Then with win=1, lose=0, a read of addr 4 returns 0x01; miso_oe=0 whenever ss_n is high.
- Async reset mid-frame: Reset_n pulled low during DATA -> all outputs at reset values within the same cycle; a subsequent read of addr 7 returns 0xA5.
